// File: rtl/inv_cipher_core_if.sv
// ---------------------------------------------------------------------------
// inv_cipher_core_if
// Bus bundle between a host/key store and the AES-128 decryption core.
//
//   startTransition  host -> core  start request, honoured only when idle
//   inputData[127:0] host -> core  ciphertext, byte 0 in [127:120]
//   roundKey[127:0]  host -> core  round key for roundKeyIndex, same cycle
//   roundKeyIndex[3:0] core -> host round key requested (0..10)
//   outputData[127:0] core -> host plaintext, registered
//   busy             core -> host  block in flight
//   done             core -> host  one-cycle pulse when outputData updates
//   abort            host -> core  only when AES_DEC_ABORT_EN is defined
//
// Optional feature macro: AES_DEC_ABORT_EN (adds the abort signal).
// ---------------------------------------------------------------------------
interface inv_cipher_core_if;
    logic         startTransition;
    logic [127:0] inputData;
    logic [127:0] roundKey;
    logic [3:0]   roundKeyIndex;
    logic [127:0] outputData;
    logic         busy;
    logic         done;
`ifdef AES_DEC_ABORT_EN
    logic         abort;

    modport master (
        output startTransition, inputData, roundKey, abort,
        input  roundKeyIndex, outputData, busy, done
    );
    modport slave (
        input  startTransition, inputData, roundKey, abort,
        output roundKeyIndex, outputData, busy, done
    );
`else
    modport master (
        output startTransition, inputData, roundKey,
        input  roundKeyIndex, outputData, busy, done
    );
    modport slave (
        input  startTransition, inputData, roundKey,
        output roundKeyIndex, outputData, busy, done
    );
`endif
endinterface

// File: rtl/inv_cipher_core.sv
// ---------------------------------------------------------------------------
// inv_cipher_core
// Iterative AES-128 decryption: one round per clock, ten rounds per block.
// Round keys are fetched from an external key store, 10 down to 0, through
// bus.roundKeyIndex / bus.roundKey.
//
// Ports:
//   clock50MHz  system clock, rising edge
//   resetN      synchronous active-low reset
//   bus         inv_cipher_core_if.slave (start, data, key port, status)
//
// Optional feature macro: AES_DEC_ABORT_EN
//   defined   : bus.abort high while busy returns the core to IDLE at the
//               next edge with no done pulse and outputData untouched.
//   undefined : no abort; every accepted block runs to completion.
//
// Latency: start accepted at E0, rounds 9..1 on E1..E9, final round on E10,
// done/outputData valid after E10. Back-to-back: one block per 11 cycles.
// ---------------------------------------------------------------------------
module inv_cipher_core (
    input logic            clock50MHz,
    input logic            resetN,
    inv_cipher_core_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE,
        ROUND,
        FINAL
    } fsmState_t;

    fsmState_t    fsmState;
    logic [127:0] stateReg;
    logic [3:0]   roundCnt;

    logic [127:0] shifted;
    logic [127:0] subbed;
    logic [127:0] keyed;
    logic [127:0] roundOut;
    logic         abortReq;

`ifdef AES_DEC_ABORT_EN
    assign abortReq = bus.abort;
`else
    assign abortReq = 1'b0;
`endif

    // GF(2^8) multiply, reduction polynomial x^8+x^4+x^3+x+1 (0x11b).
    function automatic logic [7:0] gfMul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) begin
                p = p ^ aa;
            end
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Inverse S-box as logic: undo the affine transform, then take the
    // multiplicative inverse as t^254 (0 maps to 0 naturally).
    function automatic logic [7:0] invSbox(input logic [7:0] b);
        logic [7:0] t;
        logic [7:0] sq;
        logic [7:0] acc;
        t   = {b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05;
        acc = 8'h01;
        sq  = t;
        // acc accumulates t^2 * t^4 * ... * t^128 = t^254
        for (int i = 0; i < 7; i++) begin
            sq  = gfMul(sq, sq);
            acc = gfMul(acc, sq);
        end
        return acc;
    endfunction

    // InvShiftRows + InvSubBytes, one S-box per byte. Byte k sits at row k%4,
    // column k/4; row r rotates right by r, so it reads from column (c-r) mod 4.
    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_byte
            localparam int ROW = gi % 4;
            localparam int COL = gi / 4;
            localparam int SRC = ROW + 4 * ((COL - ROW + 4) % 4);
            assign shifted[127 - 8 * gi -: 8] = stateReg[127 - 8 * SRC -: 8];
            assign subbed[127 - 8 * gi -: 8]  = invSbox(shifted[127 - 8 * gi -: 8]);
        end
    endgenerate

    // In the final round this is the plaintext (no InvMixColumns).
    assign keyed = subbed ^ bus.roundKey;

    generate
        for (gi = 0; gi < 4; gi++) begin : g_mix
            logic [7:0] a0;
            logic [7:0] a1;
            logic [7:0] a2;
            logic [7:0] a3;
            assign a0 = keyed[127 - 32 * gi -: 8];
            assign a1 = keyed[119 - 32 * gi -: 8];
            assign a2 = keyed[111 - 32 * gi -: 8];
            assign a3 = keyed[103 - 32 * gi -: 8];
            assign roundOut[127 - 32 * gi -: 8] =
                gfMul(a0, 8'h0e) ^ gfMul(a1, 8'h0b) ^ gfMul(a2, 8'h0d) ^ gfMul(a3, 8'h09);
            assign roundOut[119 - 32 * gi -: 8] =
                gfMul(a0, 8'h09) ^ gfMul(a1, 8'h0e) ^ gfMul(a2, 8'h0b) ^ gfMul(a3, 8'h0d);
            assign roundOut[111 - 32 * gi -: 8] =
                gfMul(a0, 8'h0d) ^ gfMul(a1, 8'h09) ^ gfMul(a2, 8'h0e) ^ gfMul(a3, 8'h0b);
            assign roundOut[103 - 32 * gi -: 8] =
                gfMul(a0, 8'h0b) ^ gfMul(a1, 8'h0d) ^ gfMul(a2, 8'h09) ^ gfMul(a3, 8'h0e);
        end
    endgenerate

    // Control FSM. roundKeyIndex is registered and always points at the key
    // the current state consumes: 10 in IDLE, r in ROUND, 0 in FINAL.
    always_ff @(posedge clock50MHz) begin
        if (!resetN) begin
            fsmState          <= IDLE;
            stateReg          <= '0;
            roundCnt          <= '0;
            bus.roundKeyIndex <= 4'd10;
            bus.outputData    <= '0;
            bus.busy          <= 1'b0;
            bus.done          <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            case (fsmState)
                IDLE: begin
                    // abort together with start in IDLE suppresses the start
                    if (bus.startTransition && !abortReq) begin
                        stateReg          <= bus.inputData ^ bus.roundKey;
                        roundCnt          <= 4'd9;
                        bus.roundKeyIndex <= 4'd9;
                        bus.busy          <= 1'b1;
                        fsmState          <= ROUND;
                    end
                end
                ROUND: begin
                    if (abortReq) begin
                        fsmState          <= IDLE;
                        roundCnt          <= '0;
                        bus.roundKeyIndex <= 4'd10;
                        bus.busy          <= 1'b0;
                    end else begin
                        stateReg <= roundOut;
                        if (roundCnt == 4'd1) begin
                            roundCnt          <= '0;
                            bus.roundKeyIndex <= 4'd0;
                            fsmState          <= FINAL;
                        end else begin
                            roundCnt          <= roundCnt - 4'd1;
                            bus.roundKeyIndex <= roundCnt - 4'd1;
                        end
                    end
                end
                FINAL: begin
                    // abort here wins: the result is dropped
                    if (!abortReq) begin
                        bus.outputData <= keyed;
                        bus.done       <= 1'b1;
                    end
                    fsmState          <= IDLE;
                    bus.roundKeyIndex <= 4'd10;
                    bus.busy          <= 1'b0;
                end
                default: begin
                    fsmState          <= IDLE;
                    bus.roundKeyIndex <= 4'd10;
                    bus.busy          <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_inv_cipher_core.sv
// ---------------------------------------------------------------------------
// tb_inv_cipher_core
// Bench for inv_cipher_core. The reference is an AES-128 *encryption* model
// with its own key schedule: random plaintexts are encrypted here and the
// core must return the original plaintext. FIPS-197 vectors are constants.
// Set AES_DEC_ABORT_EN to also exercise the abort feature.
// ---------------------------------------------------------------------------
module tb_inv_cipher_core;

    localparam int INJ_NONE  = 0;
    localparam int INJ_START = 1;
    localparam int INJ_RESET = 2;
    localparam int INJ_ABORT = 3;

    localparam logic [127:0] KEY_C1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] PT_C1  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] KEY_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;

    logic clock50MHz = 1'b0;
    logic resetN;

    inv_cipher_core_if bus ();

    inv_cipher_core dut (
        .clock50MHz (clock50MHz),
        .resetN     (resetN),
        .bus        (bus)
    );

    always #10 clock50MHz = ~clock50MHz;

    int testsRun    = 0;
    int testsFailed = 0;
    int cycleCount  = 0;

    always @(posedge clock50MHz) cycleCount <= cycleCount + 1;

    logic [7:0]   sboxTab [256];
    logic [127:0] ks      [16];

    // combinational key store
    assign bus.roundKey = ks[bus.roundKeyIndex];

    // observations collected by runBlock, one per cycle after the start edge
    logic [3:0]   obsIdx  [21];
    logic         obsBusy [21];
    logic [127:0] obsOut  [21];
    logic [3:0]   preIdx;
    int           doneCycle;

    // ---------------- reference model ----------------
    function automatic logic [7:0] gmulRef(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        p = 16'h0;
        for (int i = 0; i < 8; i++)
            if (b[i]) p = p ^ ({8'h00, a} << i);
        for (int i = 14; i >= 8; i--)
            if (p[i]) p = p ^ (16'h011b << (i - 8));
        return p[7:0];
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        logic [15:0] d;
        d = {x, x} << n;
        return d[15:8];
    endfunction

    task automatic buildSbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmulRef(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sboxTab[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3)
                       ^ rotl8(inv, 4) ^ 8'h63;
        end
        for (int i = 0; i < 16; i++) ks[i] = '0;
    endtask

    task automatic expandKey(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32 * i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i - 1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sboxTab[t[31:24]], sboxTab[t[23:16]], sboxTab[t[15:8]], sboxTab[t[7:0]]}
                    ^ {rc, 24'h0};
                rc = gmulRef(rc, 8'h02);
            end
            w[i] = w[i - 4] ^ t;
        end
        for (int r = 0; r < 11; r++)
            ks[r] = {w[4 * r], w[4 * r + 1], w[4 * r + 2], w[4 * r + 3]};
    endtask

    function automatic logic [127:0] encryptBlock(input logic [127:0] pt);
        logic [7:0] s [16];
        logic [7:0] t [16];
        logic [7:0] a0, a1, a2, a3;
        logic [127:0] res;
        for (int i = 0; i < 16; i++) s[i] = pt[127 - 8 * i -: 8] ^ ks[0][127 - 8 * i -: 8];
        for (int rnd = 1; rnd <= 10; rnd++) begin
            for (int i = 0; i < 16; i++) t[i] = sboxTab[s[i]];
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++)
                    s[r + 4 * c] = t[r + 4 * ((c + r) % 4)];
            if (rnd < 10) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = s[4 * c]; a1 = s[4 * c + 1]; a2 = s[4 * c + 2]; a3 = s[4 * c + 3];
                    s[4 * c]     = gmulRef(a0, 8'h02) ^ gmulRef(a1, 8'h03) ^ a2 ^ a3;
                    s[4 * c + 1] = a0 ^ gmulRef(a1, 8'h02) ^ gmulRef(a2, 8'h03) ^ a3;
                    s[4 * c + 2] = a0 ^ a1 ^ gmulRef(a2, 8'h02) ^ gmulRef(a3, 8'h03);
                    s[4 * c + 3] = gmulRef(a0, 8'h03) ^ a1 ^ a2 ^ gmulRef(a3, 8'h02);
                end
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ ks[rnd][127 - 8 * i -: 8];
        end
        for (int i = 0; i < 16; i++) res[127 - 8 * i -: 8] = s[i];
        return res;
    endfunction

    // ---------------- stimulus driver ----------------
    // Pulses start at the current negedge and watches up to 20 cycles.
    // lat = cycles from the start edge to done, -1 if done never came.
    task automatic runBlock(input logic [127:0] ct, input int injectAt, input int injectKind,
                            output logic [127:0] pt, output int lat);
        preIdx              = bus.roundKeyIndex;
        bus.inputData       = ct;
        bus.startTransition = 1'b1;
        @(negedge clock50MHz);
        bus.startTransition = 1'b0;
        lat = -1;
        pt  = '0;
        for (int i = 0; i <= 20; i++) begin
            if (i > 0) @(negedge clock50MHz);
            obsIdx[i]  = bus.roundKeyIndex;
            obsBusy[i] = bus.busy;
            obsOut[i]  = bus.outputData;
            bus.startTransition = 1'b0;
            resetN = 1'b1;
`ifdef AES_DEC_ABORT_EN
            bus.abort = 1'b0;
`endif
            if (bus.done) begin
                lat       = i;
                pt        = bus.outputData;
                doneCycle = cycleCount;
                break;
            end
            if (i == injectAt) begin
                case (injectKind)
                    INJ_START: begin
                        bus.inputData       = {$urandom, $urandom, $urandom, $urandom};
                        bus.startTransition = 1'b1;
                    end
                    INJ_RESET: resetN = 1'b0;
`ifdef AES_DEC_ABORT_EN
                    INJ_ABORT: bus.abort = 1'b1;
`endif
                    default: ;
                endcase
            end
        end
        $display("[TB] block ct=%h pt=%h latency=%0d", ct, pt, lat);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        resetN = 1'b0;
        repeat (3) @(negedge clock50MHz);
        testsRun++;
        if (bus.outputData !== 128'h0) begin
            testsFailed++; $display("FAIL reset_outputData got %h want 0", bus.outputData);
        end
        testsRun++;
        if (bus.done !== 1'b0) begin
            testsFailed++; $display("FAIL reset_done got %b want 0", bus.done);
        end
        testsRun++;
        if (bus.busy !== 1'b0) begin
            testsFailed++; $display("FAIL reset_busy got %b want 0", bus.busy);
        end
        testsRun++;
        if (bus.roundKeyIndex !== 4'd10) begin
            testsFailed++; $display("FAIL reset_index got %0d want 10", bus.roundKeyIndex);
        end
        resetN = 1'b1;
        @(negedge clock50MHz);
    endtask

    task automatic test_fips_c1();
        logic [127:0] pt;
        int lat;
        int busyCnt;
        expandKey(KEY_C1);
        runBlock(CT_C1, -1, INJ_NONE, pt, lat);
        busyCnt = 0;
        for (int i = 0; i <= 20; i++)
            if (lat >= 0 && i <= lat && obsBusy[i] === 1'b1) busyCnt++;
        testsRun++;
        if (pt !== PT_C1) begin
            testsFailed++; $display("FAIL c1_plaintext got %h want %h", pt, PT_C1);
        end
        testsRun++;
        if (lat != 10) begin
            testsFailed++; $display("FAIL c1_latency got %0d want 10", lat);
        end
        testsRun++;
        if (busyCnt != 10) begin
            testsFailed++; $display("FAIL c1_busy_cycles got %0d want 10", busyCnt);
        end
    endtask

    task automatic test_fips_b_trace();
        logic [127:0] pt;
        int lat;
        logic [3:0] expIdx;
        expandKey(KEY_B);
        runBlock(CT_B, -1, INJ_NONE, pt, lat);
        testsRun++;
        if (pt !== PT_B) begin
            testsFailed++; $display("FAIL b_plaintext got %h want %h", pt, PT_B);
        end
        testsRun++;
        if (preIdx !== 4'd10) begin
            testsFailed++; $display("FAIL b_idle_index got %0d want 10", preIdx);
        end
        for (int i = 0; i <= 10; i++) begin
            expIdx = (i <= 8) ? 4'(9 - i) : ((i == 9) ? 4'd0 : 4'd10);
            testsRun++;
            if (obsIdx[i] !== expIdx) begin
                testsFailed++;
                $display("FAIL b_index_trace[%0d] got %0d want %0d", i, obsIdx[i], expIdx);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [127:0] pt1, pt2;
        int lat1, lat2, d1;
        int holdBad;
        expandKey(KEY_B);
        runBlock(CT_B, -1, INJ_NONE, pt1, lat1);
        d1 = doneCycle;
        // next start issued on the done cycle
        expandKey(KEY_C1);
        runBlock(CT_C1, -1, INJ_NONE, pt2, lat2);
        holdBad = 0;
        for (int i = 0; i < 20; i++)
            if (i < lat2 && obsOut[i] !== PT_B) holdBad++;
        testsRun++;
        if (pt1 !== PT_B) begin
            testsFailed++; $display("FAIL b2b_first got %h want %h", pt1, PT_B);
        end
        testsRun++;
        if (pt2 !== PT_C1) begin
            testsFailed++; $display("FAIL b2b_second got %h want %h", pt2, PT_C1);
        end
        testsRun++;
        if (lat2 < 0 || doneCycle - d1 != 11) begin
            testsFailed++;
            $display("FAIL b2b_done_spacing got %0d want 11", (lat2 < 0) ? -1 : doneCycle - d1);
        end
        testsRun++;
        if (holdBad != 0) begin
            testsFailed++; $display("FAIL b2b_output_hold got %0d bad cycles want 0", holdBad);
        end
    endtask

    task automatic test_start_while_busy();
        logic [127:0] pt;
        int lat;
        expandKey(KEY_C1);
        runBlock(CT_C1, 4, INJ_START, pt, lat);
        testsRun++;
        if (pt !== PT_C1) begin
            testsFailed++; $display("FAIL busy_start_plaintext got %h want %h", pt, PT_C1);
        end
        testsRun++;
        if (lat != 10) begin
            testsFailed++; $display("FAIL busy_start_latency got %0d want 10", lat);
        end
        @(negedge clock50MHz);
        testsRun++;
        if (bus.busy !== 1'b0) begin
            testsFailed++; $display("FAIL busy_start_not_queued got busy=%b want 0", bus.busy);
        end
    endtask

    task automatic test_reset_midrun();
        logic [127:0] pt;
        int lat;
        expandKey(KEY_C1);
        runBlock(CT_C1, 3, INJ_RESET, pt, lat);
        testsRun++;
        if (lat != -1) begin
            testsFailed++; $display("FAIL rst_no_done got latency %0d want none", lat);
        end
        testsRun++;
        if (bus.outputData !== 128'h0) begin
            testsFailed++; $display("FAIL rst_outputData got %h want 0", bus.outputData);
        end
        testsRun++;
        if (obsBusy[4] !== 1'b0 || bus.busy !== 1'b0) begin
            testsFailed++; $display("FAIL rst_busy got %b want 0", obsBusy[4]);
        end
        testsRun++;
        if (obsIdx[4] !== 4'd10) begin
            testsFailed++; $display("FAIL rst_index got %0d want 10", obsIdx[4]);
        end
        runBlock(CT_C1, -1, INJ_NONE, pt, lat);
        testsRun++;
        if (pt !== PT_C1 || lat != 10) begin
            testsFailed++;
            $display("FAIL rst_recover got %h lat %0d want %h lat 10", pt, lat, PT_C1);
        end
    endtask

    task automatic test_random();
        logic [127:0] key, ptRef, ct, pt;
        int lat;
        for (int n = 0; n < 6; n++) begin
            key   = {$urandom, $urandom, $urandom, $urandom};
            ptRef = {$urandom, $urandom, $urandom, $urandom};
            expandKey(key);
            ct = encryptBlock(ptRef);
            runBlock(ct, -1, INJ_NONE, pt, lat);
            testsRun++;
            if (pt !== ptRef || lat != 10) begin
                testsFailed++;
                $display("FAIL random[%0d] got %h lat %0d want %h lat 10", n, pt, lat, ptRef);
            end
        end
    endtask

`ifdef AES_DEC_ABORT_EN
    task automatic test_abort();
        logic [127:0] prev, pt;
        int lat;
        expandKey(KEY_B);
        prev = bus.outputData;
        runBlock(CT_B, 6, INJ_ABORT, pt, lat);
        testsRun++;
        if (lat != -1) begin
            testsFailed++; $display("FAIL abort_no_done got latency %0d want none", lat);
        end
        testsRun++;
        if (obsBusy[6] !== 1'b1 || obsBusy[7] !== 1'b0) begin
            testsFailed++;
            $display("FAIL abort_idle got busy %b,%b want 1,0", obsBusy[6], obsBusy[7]);
        end
        testsRun++;
        if (obsIdx[7] !== 4'd10) begin
            testsFailed++; $display("FAIL abort_index got %0d want 10", obsIdx[7]);
        end
        testsRun++;
        if (bus.outputData !== prev) begin
            testsFailed++; $display("FAIL abort_output got %h want %h", bus.outputData, prev);
        end
        // abort with start in IDLE must not start a run
        bus.inputData       = CT_B;
        bus.startTransition = 1'b1;
        bus.abort           = 1'b1;
        @(negedge clock50MHz);
        bus.startTransition = 1'b0;
        bus.abort           = 1'b0;
        testsRun++;
        if (bus.busy !== 1'b0) begin
            testsFailed++; $display("FAIL abort_idle_start got busy %b want 0", bus.busy);
        end
    endtask
`endif

    initial begin
        resetN              = 1'b0;
        bus.startTransition = 1'b0;
        bus.inputData       = '0;
`ifdef AES_DEC_ABORT_EN
        bus.abort           = 1'b0;
`endif
        buildSbox();
        test_reset();
        test_fips_c1();
        test_fips_b_trace();
        test_back_to_back();
        test_start_while_busy();
        test_reset_midrun();
        test_random();
`ifdef AES_DEC_ABORT_EN
        test_abort();
`endif
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
